reg_file_2r1w: RTL and testbench

//   General-purpose register file of the multicycle CPU: two combinational read

---
 rtl/reg_file_2r1w.sv | 109 ++++++++++
 tb/tb_reg_file_2r1w.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: CPU general-purpose register file. Two combinational read
// ports with write-first bypass, one write port, optional hardwired-zero
// entry 0, and a saturating count of committed writes.

// One read port: zero-entry override, same-cycle write bypass, array read.
module reg_file_rd_port #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic                                  reset,
  input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0]    mem,
  input  logic [ADDR_W-1:0]                     addr,
  input  logic                                  we,
  input  logic [ADDR_W-1:0]                     wr_addr,
  input  logic [DATA_W-1:0]                     wr_data,
  output logic [DATA_W-1:0]                     rd_data
);

  // Priority: reset forces 0, then the zero entry, then bypass, then storage.
  always_comb begin
    rd_data = mem[addr];
    if (reset)
      rd_data = '0;
    else if ((ZERO_REG != 0) && (addr == '0))
      rd_data = '0;
    else if (we && (wr_addr == addr))
      rd_data = wr_data;
  end

endmodule

module reg_file_2r1w #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [15:0]       wr_count
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int NPORT = 2;

  logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
  logic [15:0]                  wr_count_q, wr_count_d;
  logic                         wr_commit;

  logic [NPORT-1:0][ADDR_W-1:0] rd_addr;
  logic [NPORT-1:0][DATA_W-1:0] rd_data;

  // A write commits unless it targets the hardwired zero entry; an X on we
  // resolves to "no write", so idle X inputs leave storage untouched.
  always_comb begin
    mem_d      = mem_q;
    wr_count_d = wr_count_q;
    wr_commit  = 1'b0;
    if (we && !((ZERO_REG != 0) && (wr_addr == '0)))
      wr_commit = 1'b1;
    if (wr_commit) begin
      mem_d[wr_addr] = wr_data;
      if (wr_count_q != 16'hFFFF)
        wr_count_d = wr_count_q + 16'd1;
    end
  end

  // Storage and write counter; the asynchronous clear beats any pending write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q      <= '0;
      wr_count_q <= '0;
    end else begin
      mem_q      <= mem_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign rd_addr[0] = rs_addr;
  assign rd_addr[1] = rt_addr;

  for (genvar p = 0; p < NPORT; p++) begin : g_rd
    reg_file_rd_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
    ) u_port (
      .reset   (reset),
      .mem     (mem_q),
      .addr    (rd_addr[p]),
      .we      (we),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_data (rd_data[p])
    );
  end

  assign rd_data_a = rd_data[0];
  assign rd_data_b = rd_data[1];
  assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// tb_reg_file_2r1w: scoreboard bench for the 2R1W register file. Stimulus
// pushes expected read/count values computed from an array model; a monitor
// pops and compares whenever a sample is presented.
`timescale 1ns/100ps
module tb_reg_file_2r1w;

  logic        clk = 1'b0;
  logic        clk_on = 1'b0;
  logic        rst;
  logic [4:0]  rs, rt, wa;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rda, rdb;
  logic [15:0] wcnt;

  reg_file_2r1w #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
    .clk       (clk),
    .reset     (rst),
    .rs_addr   (rs),
    .rt_addr   (rt),
    .rd_data_a (rda),
    .rd_data_b (rdb),
    .we        (we),
    .wr_addr   (wa),
    .wr_data   (wd),
    .wr_count  (wcnt)
  );

  // Clock held low until the reset-only checks are done.
  initial begin
    wait (clk_on);
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       nm;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [15:0] ec;
  } exp_t;

  exp_t        sbq[$];
  event        chk_ev;
  int          checks = 0;
  int          errors = 0;

  // Reference model: plain array of register contents and a write tally.
  logic [31:0] model [32];
  int unsigned cnt;

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (rst)                   return 32'h0;
    if (a == 5'd0)             return 32'h0;
    if (we === 1'b1 && wa == a) return wd;
    return model[a];
  endfunction

  task automatic cmp(input string nm, input string what,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s got=%h want=%h @%0t", nm, what, act, exp, $time);
    end
  endtask

  // Monitor: every presented sample is compared against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(chk_ev);
      while (sbq.size() > 0) begin
        e = sbq.pop_front();
        cmp(e.nm, "rd_data_a", rda, e.ea);
        cmp(e.nm, "rd_data_b", rdb, e.eb);
        cmp(e.nm, "wr_count", {16'h0, wcnt}, {16'h0, e.ec});
      end
    end
  end

  task automatic drive(input logic w, input logic [4:0] a, input logic [31:0] d,
                       input logic [4:0] ra, input logic [4:0] rb);
    we = w; wa = a; wd = d; rs = ra; rt = rb;
  endtask

  task automatic check(input string nm);
    exp_t e;
    #1;
    e.nm = nm;
    e.ea = exp_rd(rs);
    e.eb = exp_rd(rt);
    e.ec = rst ? 16'h0 : cnt[15:0];
    sbq.push_back(e);
    -> chk_ev;
    #0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    cnt = 0;
  endtask

  // One rising edge; the model commits what the inputs held at that edge.
  task automatic tick();
    @(posedge clk);
    if (!rst && we && wa != 5'd0) begin
      model[wa] = wd;
      if (cnt < 32'd65535) cnt++;
    end
    #1;
  endtask

  initial begin
    rst = 1'b1;
    model_clear();
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    #1;
    // Reset with no clock edge: every address reads zero on both ports.
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
      check("rst_read");
    end
    drive(1'b1, 5'd4, 32'h5555AAAA, 5'd4, 5'd4);
    check("rst_bypass");
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    clk_on = 1'b1;
    #2 rst = 1'b0;

    // First write after reset release.
    drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
    check("wr_r5");

    // Bypass before the edge, then storage after.
    drive(1'b1, 5'd7, 32'h1234, 5'd0, 5'd7);
    check("bypass_pre");
    tick();
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd7);
    check("bypass_post");

    // Zero register ignores writes and does not count them.
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    check("r0_pre");
    tick();
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    check("r0_post");

    // Reset pulse between edges clears r3; next write works.
    drive(1'b1, 5'd3, 32'hA, 5'd3, 5'd3);
    tick();
    drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
    check("r3_a");
    #2;
    rst = 1'b1;
    model_clear();
    check("r3_in_rst");
    #1;
    rst = 1'b0;
    check("r3_cleared");
    drive(1'b1, 5'd3, 32'hB, 5'd3, 5'd7);
    tick();
    drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
    check("r3_b");

    // Reset held across a write edge: the clear wins.
    drive(1'b1, 5'd9, 32'h0BAD0BAD, 5'd9, 5'd3);
    #2;
    rst = 1'b1;
    model_clear();
    tick();
    check("rst_edge_in");
    drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd3);
    rst = 1'b0;
    check("rst_edge_out");

    // X on the write inputs with we low must not disturb storage.
    drive(1'b0, 5'bxxxxx, 32'hxxxxxxxx, 5'd1, 5'd2);
    tick();
    drive(1'b0, 5'd0, 32'h0, 5'd1, 5'd2);
    check("x_idle");

    // Randomized traffic with biased address overlap.
    repeat (300) begin
      logic [4:0] a, ra, rb;
      a  = 5'($urandom_range(0, 31));
      ra = ($urandom_range(0, 3) == 0) ? a : 5'($urandom_range(0, 31));
      rb = ($urandom_range(0, 3) == 0) ? a : 5'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) rb = ra;
      drive(1'($urandom_range(0, 1)), a, $urandom, ra, rb);
      check("rand");
      tick();
    end
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd7);
    check("rand_end");

    // Saturation of the write counter from a preload.
    force dut.wr_count_q = 16'hFFFE;
    #1;
    release dut.wr_count_q;
    cnt = 65534;
    check("sat_pre");
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 5'(10 + k), 32'h100 + 32'(k), 5'(10 + k), 5'd1);
      tick();
      drive(1'b0, 5'd0, 32'h0, 5'(10 + k), 5'd1);
      check("sat");
    end

    #5;
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain left=%0d want=0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
